// File: rtl/psum_buffer.sv
// Partial-sum store beside the systolic MVM array. It replays stored sums on each filter-tap pass.
// On the last pass it streams the array output to the result port through a 2-entry skid FIFO.
module psum_buffer #(
  parameter int unsigned ARRAY_DIM_X       = 16,
  parameter int unsigned OUT_DATA_BITWIDTH = 32,
  parameter int unsigned DEPTH             = 64,
  parameter int unsigned ADDR_BITWIDTH     = 6,
  localparam int unsigned W                = ARRAY_DIM_X * OUT_DATA_BITWIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pass_start,
  input  logic [ADDR_BITWIDTH:0] cfg_num_vec,
  input  logic                   cfg_first_pass,
  input  logic                   cfg_last_pass,
  output logic                   busy,
  output logic                   pass_done,
  input  logic                   psum_rd_en,
  output logic [W-1:0]           part_out_in,
  output logic                   part_out_vld,
  input  logic [W-1:0]           data_out,
  input  logic                   data_out_vld,
  output logic                   stall,
  output logic [W-1:0]           res_data,
  output logic                   res_vld,
  input  logic                   res_ready,
  output logic                   ovf_err
);

  localparam int unsigned CntW = ADDR_BITWIDTH + 1;
  localparam logic [CntW-1:0] CntOne = 1;

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] num_vec_q, num_vec_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [W-1:0]    part_out_q, part_out_d;
  logic            part_vld_q, part_vld_d;
  logic            pass_done_q, pass_done_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    fifo_q [2];
  logic [W-1:0]    fifo_d [2];
  logic            fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [W-1:0]    mem_q [DEPTH];

  logic full, pop, push, drop, wr_ok, wr_fire, rd_fire, mem_we, fifo_wr_slot;

  assign full    = (fifo_cnt_q == 2'd2);
  assign pop     = (fifo_cnt_q != 2'd0) && res_ready;
  // A vector arriving while full is only lost if the head is not leaving in the same cycle.
  assign drop    = data_out_vld && full && !pop;
  assign wr_ok   = (state_q == StActive) && data_out_vld && (wr_cnt_q < num_vec_q);
  assign wr_fire = wr_ok && !drop;
  assign rd_fire = (state_q == StActive) && psum_rd_en && (rd_cnt_q < num_vec_q);
  assign mem_we  = wr_fire && !last_q;
  assign push    = wr_fire && last_q;
  assign fifo_wr_slot = fifo_rd_ptr_q ^ fifo_cnt_q[0];

  always_comb begin
    state_d       = state_q;
    num_vec_d     = num_vec_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    first_d       = first_q;
    last_d        = last_q;
    part_out_d    = part_out_q;
    part_vld_d    = 1'b0;
    pass_done_d   = 1'b0;
    ovf_d         = ovf_q | drop;
    fifo_d        = fifo_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;

    if (rd_fire) begin
      part_vld_d = 1'b1;
      part_out_d = first_q ? '0 : mem_q[rd_cnt_q[ADDR_BITWIDTH-1:0]];
      rd_cnt_d   = rd_cnt_q + CntOne;
    end
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + CntOne;
    end

    if (push) begin
      fifo_d[fifo_wr_slot] = data_out;
    end
    if (pop) begin
      fifo_rd_ptr_d = ~fifo_rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case (state_q)
      StIdle: begin
        if (pass_start) begin
          num_vec_d = cfg_num_vec;
          first_d   = cfg_first_pass;
          last_d    = cfg_last_pass;
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          if (cfg_num_vec == '0) begin
            pass_done_d = 1'b1;
          end else begin
            state_d = StActive;
          end
        end
      end
      StActive: begin
        if (wr_fire && (wr_cnt_d == num_vec_q)) begin
          if (!last_q || (fifo_cnt_d == 2'd0)) begin
            state_d     = StIdle;
            pass_done_d = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (fifo_cnt_d == 2'd0) begin
          state_d     = StIdle;
          pass_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      num_vec_q     <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      part_out_q    <= '0;
      part_vld_q    <= 1'b0;
      pass_done_q   <= 1'b0;
      ovf_q         <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      num_vec_q     <= num_vec_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      first_q       <= first_d;
      last_q        <= last_d;
      part_out_q    <= part_out_d;
      part_vld_q    <= part_vld_d;
      pass_done_q   <= pass_done_d;
      ovf_q         <= ovf_d;
      fifo_q        <= fifo_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // Storage array is not reset; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_cnt_q[ADDR_BITWIDTH-1:0]] <= data_out;
    end
  end

  assign busy         = (state_q != StIdle);
  assign pass_done    = pass_done_q;
  assign part_out_in  = part_out_q;
  assign part_out_vld = part_vld_q;
  assign stall        = full;
  assign res_data     = fifo_q[fifo_rd_ptr_q];
  assign res_vld      = (fifo_cnt_q != 2'd0);
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_psum_buffer.sv
// Scoreboard bench for psum_buffer: stimulus pushes expected replay/result vectors into queues,
// negedge monitors pop and compare whenever the DUT presents part_out_vld or a result handshake.
module tb_psum_buffer;

  localparam int unsigned X  = 16;
  localparam int unsigned B  = 32;
  localparam int unsigned W  = X * B;
  localparam int unsigned AW = 6;

  logic          clk;
  logic          reset_n;
  logic          pass_start;
  logic [AW:0]   cfg_num_vec;
  logic          cfg_first_pass;
  logic          cfg_last_pass;
  logic          busy;
  logic          pass_done;
  logic          psum_rd_en;
  logic [W-1:0]  part_out_in;
  logic          part_out_vld;
  logic [W-1:0]  data_out;
  logic          data_out_vld;
  logic          stall;
  logic [W-1:0]  res_data;
  logic          res_vld;
  logic          res_ready;
  logic          ovf_err;

  psum_buffer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pass_start     (pass_start),
    .cfg_num_vec    (cfg_num_vec),
    .cfg_first_pass (cfg_first_pass),
    .cfg_last_pass  (cfg_last_pass),
    .busy           (busy),
    .pass_done      (pass_done),
    .psum_rd_en     (psum_rd_en),
    .part_out_in    (part_out_in),
    .part_out_vld   (part_out_vld),
    .data_out       (data_out),
    .data_out_vld   (data_out_vld),
    .stall          (stall),
    .res_data       (res_data),
    .res_vld        (res_vld),
    .res_ready      (res_ready),
    .ovf_err        (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_part [$];
  logic [W-1:0] exp_res  [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W-1:0] vec(input int unsigned v);
    logic [B-1:0] col;
    col = B'(v);
    return {X{col}};
  endfunction

  task automatic chk_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Replay monitor
  always @(negedge clk) begin
    if (reset_n && part_out_vld) begin
      if (exp_part.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL part_unexpected: got vld=1 data %0h expected no valid", part_out_in);
      end else begin
        chk_vec("part_out_in", part_out_in, exp_part.pop_front());
      end
    end
  end

  // Result monitor: the handshake completes at the following posedge
  always @(negedge clk) begin
    if (reset_n && res_vld && res_ready) begin
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL res_unexpected: got vld=1 data %0h expected no valid", res_data);
      end else begin
        chk_vec("res_data", res_data, exp_res.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input int n, input logic first, input logic last);
    pass_start     = 1'b1;
    cfg_num_vec    = 7'(n);
    cfg_first_pass = first;
    cfg_last_pass  = last;
    tick();
    pass_start = 1'b0;
  endtask

  task automatic quiet();
    psum_rd_en   = 1'b0;
    data_out_vld = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b1;
    pass_start     = 1'b0;
    cfg_num_vec    = '0;
    cfg_first_pass = 1'b0;
    cfg_last_pass  = 1'b0;
    psum_rd_en     = 1'b0;
    data_out       = '0;
    data_out_vld   = 1'b0;
    res_ready      = 1'b0;
    #1 reset_n = 1'b0;
    #6;
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_pass_done", pass_done, 1'b0);
    chk_bit("rst_part_vld", part_out_vld, 1'b0);
    chk_vec("rst_part_out", part_out_in, '0);
    chk_bit("rst_stall", stall, 1'b0);
    chk_bit("rst_res_vld", res_vld, 1'b0);
    chk_vec("rst_res_data", res_data, '0);
    chk_bit("rst_ovf", ovf_err, 1'b0);
    #15 reset_n = 1'b1;
    tick();

    // First pass: zeros replayed, 1..4 stored
    start_pass(4, 1'b1, 1'b0);
    chk_bit("p1_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      psum_rd_en   = 1'b1;
      exp_part.push_back(vec(0));
      data_out     = vec(i + 1);
      data_out_vld = 1'b1;
      tick();
      if (i == 0) chk_bit("p1_rd_latency", part_out_vld, 1'b1);
    end
    quiet();
    chk_bit("p1_done", pass_done, 1'b1);
    chk_bit("p1_idle", busy, 1'b0);
    tick();
    chk_bit("p1_done_pulse", pass_done, 1'b0);
    psum_rd_en = 1'b1;  // read outside ACTIVE must be ignored
    tick();
    quiet();
    chk_bit("idle_rd_ignored", part_out_vld, 1'b0);

    // Second pass: replay 1..4 while overwriting with 11..14 at the same addresses
    start_pass(4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      psum_rd_en   = 1'b1;
      exp_part.push_back(vec(i + 1));
      data_out     = vec(11 + i);
      data_out_vld = 1'b1;
      tick();
    end
    quiet();
    chk_bit("p2_done", pass_done, 1'b1);
    tick();
    chk_bit("p2_vld_low", part_out_vld, 1'b0);
    chk_vec("p2_hold", part_out_in, vec(4));

    // Third pass sees 11..14
    start_pass(4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      psum_rd_en   = 1'b1;
      exp_part.push_back(vec(11 + i));
      data_out     = vec(21 + i);
      data_out_vld = 1'b1;
      tick();
    end
    quiet();
    tick();

    // Read-before-write at address 0
    start_pass(1, 1'b0, 1'b0);
    data_out     = vec(5);
    data_out_vld = 1'b1;
    tick();
    quiet();
    tick();
    start_pass(1, 1'b0, 1'b0);
    psum_rd_en   = 1'b1;
    exp_part.push_back(vec(5));
    data_out     = vec(9);
    data_out_vld = 1'b1;
    tick();
    quiet();
    tick();
    start_pass(1, 1'b0, 1'b0);
    psum_rd_en   = 1'b1;
    exp_part.push_back(vec(9));
    data_out     = vec(7);
    data_out_vld = 1'b1;
    tick();
    quiet();
    chk_bit("rbw_done", pass_done, 1'b1);
    tick();

    // Last pass with backpressure, overflow, then drain
    res_ready = 1'b0;
    start_pass(3, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_res.push_back(vec(i + 1));
      data_out     = vec(i + 1);
      data_out_vld = 1'b1;
      tick();
    end
    chk_bit("lp_stall", stall, 1'b1);
    chk_bit("lp_res_vld", res_vld, 1'b1);
    chk_bit("lp_no_ovf_yet", ovf_err, 1'b0);
    data_out = vec(3);
    tick();
    chk_bit("lp_ovf", ovf_err, 1'b1);
    chk_vec("lp_res_hold", res_data, vec(1));
    chk_bit("lp_busy_after_drop", busy, 1'b1);
    res_ready = 1'b1;
    exp_res.push_back(vec(3));
    tick();
    data_out_vld = 1'b0;
    chk_bit("lp_full_pushpop", stall, 1'b1);
    chk_bit("lp_drain_busy", busy, 1'b1);
    chk_bit("lp_no_done_yet", pass_done, 1'b0);
    tick();
    chk_bit("lp_drain_done_early", pass_done, 1'b0);
    tick();
    chk_bit("lp_drain_done", pass_done, 1'b1);
    chk_bit("lp_drain_idle", busy, 1'b0);
    chk_bit("lp_res_empty", res_vld, 1'b0);
    tick();

    // Zero-length pass
    psum_rd_en = 1'b1;
    start_pass(0, 1'b1, 1'b0);
    chk_bit("z_done", pass_done, 1'b1);
    chk_bit("z_busy", busy, 1'b0);
    tick();
    chk_bit("z_done_pulse", pass_done, 1'b0);
    chk_bit("z_no_vld", part_out_vld, 1'b0);
    quiet();

    // pass_start while busy is ignored
    start_pass(2, 1'b1, 1'b0);
    pass_start     = 1'b1;
    cfg_num_vec    = 7'd5;
    cfg_last_pass  = 1'b1;
    data_out       = vec(31);
    data_out_vld   = 1'b1;
    tick();
    pass_start = 1'b0;
    chk_bit("ign_busy", busy, 1'b1);
    data_out = vec(32);
    tick();
    quiet();
    chk_bit("ign_done", pass_done, 1'b1);
    chk_bit("ign_idle", busy, 1'b0);
    chk_bit("ign_no_res", res_vld, 1'b0);
    tick();

    // Asynchronous reset mid-pass with one result queued
    res_ready = 1'b0;
    start_pass(3, 1'b0, 1'b1);
    data_out     = vec(41);
    data_out_vld = 1'b1;
    tick();
    quiet();
    chk_bit("mr_res_vld", res_vld, 1'b1);
    chk_bit("mr_ovf_sticky", ovf_err, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_bit("mr_busy", busy, 1'b0);
    chk_bit("mr_res_vld0", res_vld, 1'b0);
    chk_bit("mr_stall", stall, 1'b0);
    chk_bit("mr_ovf", ovf_err, 1'b0);
    #3 reset_n = 1'b1;
    tick();
    chk_bit("mr_idle_after", busy, 1'b0);

    chk_int("part_queue_drained", exp_part.size(), 0);
    chk_int("res_queue_drained", exp_res.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
